// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - byte-stream command engine driving the register memory with auto-increment bursts
// Writes stream straight to memory; reads issue one address at a time and return backpressured bytes.
module reg_access_ctrl #(
   parameter int ADDR_W  = 4,
   parameter int MEM_LAT = 1
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic [7:0]        i_Cmd_Data,
   input  logic              i_Cmd_Valid,
   output logic              o_Cmd_Ready,
   output logic [7:0]        o_Rsp_Data,
   output logic              o_Rsp_Valid,
   input  logic              i_Rsp_Ready,
   output logic [ADDR_W-1:0] o_Mem_Addr,
   output logic [7:0]        o_Mem_Data,
   output logic              o_Mem_Write,
   input  logic [7:0]        i_Mem_Data,
   output logic              o_Busy
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WR_DATA  = 3'd1;
   localparam logic [2:0] ST_RD_ISSUE = 3'd2;
   localparam logic [2:0] ST_RD_WAIT  = 3'd3;
   localparam logic [2:0] ST_RD_OUT   = 3'd4;

   // RD_ISSUE covers the first latency cycle, so RD_WAIT counts the rest.
   localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [1:0]        lat_q, lat_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [7:0]        rsp_data_q, rsp_data_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_data_q, mem_data_d;
   logic              mem_write_q, mem_write_d;
   logic              busy_q, busy_d;

   logic              cmd_fire;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] addr_inc;

   assign cmd_fire = i_Cmd_Valid & cmd_ready_q;
   assign cmd_addr = ADDR_W'(i_Cmd_Data[3:0]);
   assign addr_inc = addr_q + ADDR_W'(1);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      lat_d       = lat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      mem_write_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               addr_d = cmd_addr;
               cnt_d  = i_Cmd_Data[6:4];
               if (i_Cmd_Data[7]) begin
                  state_d = ST_WR_DATA;
               end else begin
                  // Address goes out on the accept edge so the read starts immediately.
                  state_d    = ST_RD_ISSUE;
                  mem_addr_d = cmd_addr;
               end
            end
         end
         ST_WR_DATA: begin
            if (cmd_fire) begin
               mem_write_d = 1'b1;
               mem_addr_d  = addr_q;
               mem_data_d  = i_Cmd_Data;
               addr_d      = addr_inc;
               if (cnt_q == 3'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
         end
         ST_RD_ISSUE: begin
            mem_addr_d = addr_q;
            lat_d      = LAT_LAST;
            state_d    = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (lat_q == 2'd0) begin
               rsp_data_d  = i_Mem_Data;
               rsp_valid_d = 1'b1;
               state_d     = ST_RD_OUT;
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         ST_RD_OUT: begin
            if (i_Rsp_Ready) begin
               rsp_valid_d = 1'b0;
               addr_d      = addr_inc;
               if (cnt_q == 3'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d      = cnt_q - 3'd1;
                  mem_addr_d = addr_inc;
                  state_d    = ST_RD_ISSUE;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_WR_DATA);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         cnt_q       <= 3'd0;
         lat_q       <= 2'd0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'd0;
         mem_addr_q  <= '0;
         mem_data_q  <= 8'd0;
         mem_write_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         lat_q       <= lat_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         mem_write_q <= mem_write_d;
         busy_q      <= busy_d;
      end
   end

   assign o_Cmd_Ready = cmd_ready_q;
   assign o_Rsp_Data  = rsp_data_q;
   assign o_Rsp_Valid = rsp_valid_q;
   assign o_Mem_Addr  = mem_addr_q;
   assign o_Mem_Data  = mem_data_q;
   assign o_Mem_Write = mem_write_q;
   assign o_Busy      = busy_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - bench for reg_access_ctrl with a 16 x 8 memory model and reference array
module tb_reg_access_ctrl;

   localparam int LAT1 = 1;
   localparam int LAT2 = 2;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       seed = 1'b1;
   logic [7:0] cmd_data = 8'd0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] rsp_data;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_write;
   logic [7:0] mem_rdata;
   logic       busy;

   logic [7:0] cmd_data2 = 8'd0;
   logic       cmd_valid2 = 1'b0;
   logic       cmd_ready2;
   logic [7:0] rsp_data2;
   logic       rsp_valid2;
   logic       rsp_ready2 = 1'b0;
   logic [3:0] mem_addr2;
   logic [7:0] mem_wdata2;
   logic       mem_write2;
   logic [7:0] mem_rdata2;
   logic       busy2;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  seed_pat [16];
   logic [7:0]  ref_mem  [16];
   logic [7:0]  tb_mem   [16];
   logic [7:0]  tb_mem2  [16];
   logic [7:0]  rd1, rd2a, rd2b;
   logic [11:0] wr_log [$];

   reg_access_ctrl #(.ADDR_W(4), .MEM_LAT(LAT1)) u_dut (
      .i_Clk(clk), .i_Rst(rst),
      .i_Cmd_Data(cmd_data), .i_Cmd_Valid(cmd_valid), .o_Cmd_Ready(cmd_ready),
      .o_Rsp_Data(rsp_data), .o_Rsp_Valid(rsp_valid), .i_Rsp_Ready(rsp_ready),
      .o_Mem_Addr(mem_addr), .o_Mem_Data(mem_wdata), .o_Mem_Write(mem_write),
      .i_Mem_Data(mem_rdata), .o_Busy(busy)
   );

   reg_access_ctrl #(.ADDR_W(4), .MEM_LAT(LAT2)) u_dut2 (
      .i_Clk(clk), .i_Rst(rst),
      .i_Cmd_Data(cmd_data2), .i_Cmd_Valid(cmd_valid2), .o_Cmd_Ready(cmd_ready2),
      .o_Rsp_Data(rsp_data2), .o_Rsp_Valid(rsp_valid2), .i_Rsp_Ready(rsp_ready2),
      .o_Mem_Addr(mem_addr2), .o_Mem_Data(mem_wdata2), .o_Mem_Write(mem_write2),
      .i_Mem_Data(mem_rdata2), .o_Busy(busy2)
   );

   // Registered-read memories: data appears MEM_LAT cycles after the address.
   always @(posedge clk) begin
      if (seed) begin
         for (int i = 0; i < 16; i++) begin
            tb_mem[i]  <= seed_pat[i];
            tb_mem2[i] <= seed_pat[i];
         end
      end else begin
         if (mem_write)  tb_mem[mem_addr]   <= mem_wdata;
         if (mem_write2) tb_mem2[mem_addr2] <= mem_wdata2;
      end
      if (mem_write) wr_log.push_back({mem_addr, mem_wdata});
      rd1  <= tb_mem[mem_addr];
      rd2a <= tb_mem2[mem_addr2];
      rd2b <= rd2a;
   end
   assign mem_rdata  = rd1;
   assign mem_rdata2 = rd2b;

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      cmd_data  = b;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout got cmd_ready=%b want 1", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] cmd, input logic [7:0] dat [8], input int gap_lo, input int gap_hi);
      int          len, base, got;
      logic [3:0]  a;
      logic [11:0] exp_q [$];
      len  = int'(cmd[6:4]);
      a    = cmd[3:0];
      base = wr_log.size();
      send_byte(cmd);
      for (int i = 0; i <= len; i++) begin
         if (i > 0) begin
            repeat ($urandom_range(gap_hi, gap_lo)) begin
               @(posedge clk); #1;
               n_vec++;
               if (busy !== 1'b1) begin
                  n_err++;
                  $display("FAIL wr_gap_busy got %b want 1", busy);
               end
            end
         end
         send_byte(dat[i]);
         exp_q.push_back({4'(a + 4'(i)), dat[i]});
         ref_mem[4'(a + 4'(i))] = dat[i];
      end
      repeat (2) @(posedge clk);
      #1;
      got = wr_log.size() - base;
      n_vec++;
      if (got != len + 1) begin
         n_err++;
         $display("FAIL wr_count got %0d want %0d", got, len + 1);
      end
      for (int i = 0; i <= len && i < got; i++) begin
         n_vec++;
         if (wr_log[base + i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL wr_strobe[%0d] got addr/data %h want %h", i, wr_log[base + i], exp_q[i]);
         end
      end
      n_vec++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL wr_end_idle got busy=%b ready=%b want 0 1", busy, cmd_ready);
      end
   endtask

   // mode 0: ready held high; 1: random ready delay; 2: first byte stalled 5 cycles.
   task automatic do_read(input logic [7:0] cmd, input int mode);
      int         len, base, n, last_h, w, bad;
      logic [3:0] a, ea;
      logic [7:0] exp_b, held;
      len  = int'(cmd[6:4]);
      a    = cmd[3:0];
      base = wr_log.size();
      bad  = 0;
      rsp_ready = (mode == 0);
      send_byte(cmd);
      n = 1;
      last_h = 0;
      for (int i = 0; i <= len; i++) begin
         ea = 4'(a + 4'(i));
         exp_b = ref_mem[ea];
         w = 0;
         while (!rsp_valid && w < 40) begin
            if (cmd_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            n++; w++;
         end
         n_vec++;
         if (rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rd_timeout byte %0d got valid=%b want 1", i, rsp_valid);
         end
         n_vec++;
         if (n - last_h != LAT1 + 2) begin
            n_err++;
            $display("FAIL rd_latency byte %0d got %0d cycles want %0d", i, n - last_h, LAT1 + 2);
         end
         n_vec++;
         if (rsp_data !== exp_b) begin
            n_err++;
            $display("FAIL rd_data addr %h got %h want %h", ea, rsp_data, exp_b);
         end
         n_vec++;
         if (mem_addr !== ea) begin
            n_err++;
            $display("FAIL rd_addr got %h want %h", mem_addr, ea);
         end
         if (mode == 2 && i == 0) begin
            held = rsp_data;
            repeat (5) begin
               @(posedge clk); #1;
               n++;
               n_vec++;
               if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 || mem_addr !== ea) begin
                  n_err++;
                  $display("FAIL bp_hold got v=%b d=%h rdy=%b a=%h want 1 %h 0 %h",
                           rsp_valid, rsp_data, cmd_ready, mem_addr, held, ea);
               end
            end
         end else if (mode == 1) begin
            repeat ($urandom_range(3, 0)) begin
               @(posedge clk); #1;
               n++;
            end
         end
         rsp_ready = 1'b1;
         last_h = n;
         @(posedge clk); #1;
         n++;
         rsp_ready = (mode == 0);
      end
      n_vec++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rd_end_idle got busy=%b ready=%b valid=%b want 0 1 0", busy, cmd_ready, rsp_valid);
      end
      n_vec++;
      if (wr_log.size() != base || bad != 0) begin
         n_err++;
         $display("FAIL rd_side_effects got writes=%0d ready_hi=%0d want 0 0", wr_log.size() - base, bad);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      seed = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'd0) begin
         n_err++;
         $display("FAIL reset_rsp got ready=%b valid=%b data=%h want 1 0 00", cmd_ready, rsp_valid, rsp_data);
      end
      n_vec++;
      if (mem_write !== 1'b0 || mem_addr !== 4'd0 || mem_wdata !== 8'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mem got wr=%b addr=%h data=%h busy=%b want 0 0 00 0", mem_write, mem_addr, mem_wdata, busy);
      end
      n_vec++;
      if (cmd_ready2 !== 1'b1 || rsp_valid2 !== 1'b0 || busy2 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_dut2 got ready=%b valid=%b busy=%b want 1 0 0", cmd_ready2, rsp_valid2, busy2);
      end
      rst = 1'b0;
      seed = 1'b0;
   endtask

   task automatic test_single_write_read;
      logic [7:0] dat [8];
      foreach (dat[i]) dat[i] = 8'h00;
      dat[0] = 8'hA5;
      do_write(8'h85, dat, 0, 0);
      do_read(8'h05, 0);
   endtask

   task automatic test_burst_wrap;
      logic [7:0] dat [8];
      foreach (dat[i]) dat[i] = 8'h00;
      dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
      do_write(8'hBE, dat, 0, 0);
      do_read(8'h3E, 0);
   endtask

   task automatic test_backpressure;
      do_read(8'h13, 2);
   endtask

   task automatic test_gapped_write;
      logic [7:0] dat [8];
      foreach (dat[i]) dat[i] = 8'($urandom);
      do_write(8'h92, dat, 4, 4);
   endtask

   task automatic test_random;
      logic [7:0] dat [8];
      logic [7:0] cmd;
      for (int k = 0; k < 24; k++) begin
         cmd = 8'($urandom);
         if (cmd[7]) begin
            foreach (dat[i]) dat[i] = 8'($urandom);
            do_write(cmd, dat, 0, 2);
         end else begin
            do_read(cmd, 1);
         end
      end
   endtask

   task automatic test_reset_mid_burst;
      logic [7:0] dat [8];
      int         base, w;
      base = wr_log.size();
      send_byte(8'hF0);
      for (int i = 0; i < 3; i++) begin
         dat[i] = 8'($urandom);
         send_byte(dat[i]);
         ref_mem[4'(i)] = dat[i];
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (wr_log.size() - base != 3) begin
         n_err++;
         $display("FAIL abort_writes got %0d want 3", wr_log.size() - base);
      end
      n_vec++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || mem_write !== 1'b0) begin
         n_err++;
         $display("FAIL abort_idle got busy=%b ready=%b wr=%b want 0 1 0", busy, cmd_ready, mem_write);
      end
      foreach (dat[i]) dat[i] = 8'h00;
      dat[0] = 8'h5A;
      do_write(8'h80, dat, 0, 0);
      do_read(8'h20, 0);
      rsp_ready = 1'b0;
      send_byte(8'h03);
      w = 0;
      while (!rsp_valid && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++;
      if (rsp_valid !== 1'b0 || rsp_data !== 8'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_rsp got valid=%b data=%h busy=%b want 0 00 0", rsp_valid, rsp_data, busy);
      end
   endtask

   task automatic test_mem_lat2;
      int         n, last_h, w;
      logic [3:0] ea;
      n_vec++;
      if (cmd_ready2 !== 1'b1) begin
         n_err++;
         $display("FAIL lat2_ready got %b want 1", cmd_ready2);
      end
      rsp_ready2 = 1'b1;
      cmd_data2  = 8'h17;
      cmd_valid2 = 1'b1;
      @(posedge clk); #1;
      cmd_valid2 = 1'b0;
      n = 1;
      last_h = 0;
      for (int i = 0; i < 2; i++) begin
         ea = 4'(4'd7 + 4'(i));
         w = 0;
         while (!rsp_valid2 && w < 40) begin
            @(posedge clk); #1;
            n++; w++;
         end
         n_vec++;
         if (rsp_valid2 !== 1'b1 || n - last_h != LAT2 + 2) begin
            n_err++;
            $display("FAIL lat2_latency byte %0d got valid=%b after %0d cycles want 1 after %0d",
                     i, rsp_valid2, n - last_h, LAT2 + 2);
         end
         n_vec++;
         if (rsp_data2 !== seed_pat[ea] || mem_addr2 !== ea) begin
            n_err++;
            $display("FAIL lat2_data got %h@%h want %h@%h", rsp_data2, mem_addr2, seed_pat[ea], ea);
         end
         last_h = n;
         @(posedge clk); #1;
         n++;
      end
      n_vec++;
      if (busy2 !== 1'b0 || mem_write2 !== 1'b0) begin
         n_err++;
         $display("FAIL lat2_idle got busy=%b wr=%b want 0 0", busy2, mem_write2);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         seed_pat[i] = 8'($urandom);
         ref_mem[i]  = seed_pat[i];
      end
      test_reset();
      test_single_write_read();
      test_burst_wrap();
      test_backpressure();
      test_gapped_write();
      test_random();
      test_reset_mid_burst();
      test_mem_lat2();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
